// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: capture sequencer between the CIC3 PDM decimator and the
// TinyQV register interface. Gates the mic clock, discards warm-up samples,
// captures a bounded (or continuous) run into a show-ahead FIFO and raises irq.
// Optional build macro: PDM_CAPTURE_DCBLOCK_EN adds a DC-removal stage in
// front of the FIFO write port.
module pdm_capture_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     flush_i,
    input  logic [CNT_W-1:0]         warmup_count_i,
    input  logic [CNT_W-1:0]         sample_count_i,
    input  logic [$clog2(DEPTH):0]   irq_level_i,
    input  logic                     pcm_valid_i,
    input  logic [WIDTH-1:0]         pcm_data_i,
    output logic                     mic_clk_en_o,
    output logic                     busy_o,
    output logic [1:0]               state_o,
    input  logic                     fifo_pop_i,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     done_o,
    output logic                     irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]   samp_q, samp_d;
    logic               done_q, done_d;
    logic               mic_en_q;
    logic               busy_q;
    logic               start_ok;
    logic               push_req;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               ovf_q;
    logic               fifo_full, fifo_empty;
    logic               pop_ok, push_ok, ovf_set;
    logic [WIDTH-1:0]   store_data;

    // Session sequencing; a zero sample counter in CAPTURE means continuous mode
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        samp_d   = samp_q;
        done_d   = done_q;
        start_ok = 1'b0;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    start_ok = 1'b1;
                    warm_d   = warmup_count_i;
                    samp_d   = sample_count_i;
                    done_d   = 1'b0;
                    state_d  = (warmup_count_i != '0) ? ST_WARMUP : ST_CAPTURE;
                end
            end
            ST_WARMUP: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (pcm_valid_i) begin
                    warm_d = warm_q - CNT_W'(1);
                    if (warm_q == CNT_W'(1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (pcm_valid_i) begin
                    push_req = 1'b1;
                    if (samp_q != '0) begin
                        samp_d = samp_q - CNT_W'(1);
                        if (samp_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; mic enable and busy track the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            warm_q   <= '0;
            samp_q   <= '0;
            done_q   <= 1'b0;
            mic_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            samp_q   <= samp_d;
            done_q   <= done_d;
            mic_en_q <= (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
            busy_q   <= (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
        end
    end

`ifdef PDM_CAPTURE_DCBLOCK_EN
    localparam int unsigned ACC_W = WIDTH + 6;

    // acc holds the DC estimate in 1/64 LSB units, so (y>>>6) keeps its fraction
    logic [ACC_W-1:0]   acc_q;
    logic [WIDTH:0]     dc_diff;
    logic [WIDTH-1:0]   dc_y;

    // y = x - dc, saturated to the signed sample range
    always_comb begin
        dc_diff = {pcm_data_i[WIDTH-1], pcm_data_i} - {acc_q[ACC_W-1], acc_q[ACC_W-1:6]};
        dc_y    = dc_diff[WIDTH-1:0];
        if (dc_diff[WIDTH] != dc_diff[WIDTH-1]) begin
            dc_y = dc_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        store_data = dc_y;
    end

    // Accumulator advances on every capture push attempt, cleared at session start
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            acc_q <= '0;
        end else if (push_req) begin
            acc_q <= acc_q + {{6{dc_y[WIDTH-1]}}, dc_y};
        end
    end
`else
    assign store_data = pcm_data_i;
`endif

    // FIFO handshake; flush dominates, push into a full FIFO only with a pop
    always_comb begin
        fifo_full  = (level_q == LVL_W'(DEPTH));
        fifo_empty = (level_q == '0);
        pop_ok     = fifo_pop_i && !fifo_empty && !flush_i;
        push_ok    = push_req && (!fifo_full || pop_ok) && !flush_i;
        ovf_set    = push_req && fifo_full && !pop_ok && !flush_i;
    end

    // FIFO pointers, level and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care while the level says empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= store_data;
        end
    end

    assign state_o      = state_q;
    assign mic_clk_en_o = mic_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign fifo_level_o = level_q;
    assign fifo_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign irq_o        = ((irq_level_i != '0) && (level_q >= irq_level_i)) || done_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl; expected FIFO contents are kept
// in a scoreboard queue filled as samples are driven and drained on pop.
// Build with PDM_CAPTURE_DCBLOCK_EN to also exercise the DC-removal stage.
module tb_pdm_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, flush;
    logic [15:0] warmup_count, sample_count;
    logic [3:0]  irq_level;
    logic        pcm_valid;
    logic [15:0] pcm_data;
    logic        mic_clk_en, busy, fifo_pop, overflow, done, irq;
    logic [1:0]  state;
    logic [15:0] fifo_data;
    logic [3:0]  fifo_level;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
`ifdef PDM_CAPTURE_DCBLOCK_EN
    int          m_acc = 0;
`endif

    always #5 clk = ~clk;

    pdm_capture_ctrl #(.WIDTH(16), .DEPTH(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .stop_i         (stop),
        .flush_i        (flush),
        .warmup_count_i (warmup_count),
        .sample_count_i (sample_count),
        .irq_level_i    (irq_level),
        .pcm_valid_i    (pcm_valid),
        .pcm_data_i     (pcm_data),
        .mic_clk_en_o   (mic_clk_en),
        .busy_o         (busy),
        .state_o        (state),
        .fifo_pop_i     (fifo_pop),
        .fifo_data_o    (fifo_data),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow),
        .done_o         (done),
        .irq_o          (irq)
    );

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference for what the FIFO receives for a capture-state sample
    task automatic model_in(input logic [15:0] x, input bit store);
        logic [15:0] y;
`ifdef PDM_CAPTURE_DCBLOCK_EN
        int dc;
        int d;
        dc = m_acc >>> 6;
        d  = int'($signed(x)) - dc;
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
        m_acc = m_acc + d;
        y = 16'(d);
`else
        y = x;
`endif
        if (store) exp_q.push_back(y);
    endtask

    task automatic do_start(input logic [15:0] w, input logic [15:0] s);
        warmup_count = w;
        sample_count = s;
        start = 1'b1;
        cycle();
        start = 1'b0;
`ifdef PDM_CAPTURE_DCBLOCK_EN
        m_acc = 0;
`endif
    endtask

    task automatic send(input logic [15:0] x);
        pcm_valid = 1'b1;
        pcm_data  = x;
        cycle();
        pcm_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    // Pop every expected entry and compare the show-ahead head
    task automatic drain(input string tag);
        int n;
        logic [15:0] e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (fifo_data !== e) begin errors++; $display("FAIL %s_data[%0d] got %h exp %h", tag, i, fifo_data, e); end
            fifo_pop = 1'b1;
            cycle();
            fifo_pop = 1'b0;
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL %s_empty level got %0d exp 0", tag, fifo_level); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; flush = 1'b0; fifo_pop = 1'b0;
        warmup_count = '0; sample_count = '0; irq_level = '0;
        pcm_valid = 1'b0; pcm_data = '0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if (fifo_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h exp 0", fifo_data); end
        checks++; if ({mic_clk_en, busy, overflow, done, irq} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {mic_clk_en, busy, overflow, done, irq}); end
    endtask

    task automatic test_warmup_capture();
        do_start(16'd3, 16'd4);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wu_state got %0d exp 1", state); end
        checks++; if ({mic_clk_en, busy} !== 2'b11) begin errors++; $display("FAIL wu_mic_busy got %b exp 11", {mic_clk_en, busy}); end
        for (int i = 1; i <= 10; i++) begin
            if (i >= 4 && i <= 7) model_in(16'(i), 1'b1);
            send(16'(i));
            if (i == 3) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL wu_to_cap got %0d exp 2", state); end
            end
            if (i == 7) begin
                checks++; if (state !== 2'd3) begin errors++; $display("FAIL wu_done_state got %0d exp 3", state); end
                checks++; if ({mic_clk_en, busy} !== 2'b00) begin errors++; $display("FAIL wu_done_mic got %b exp 00", {mic_clk_en, busy}); end
            end
            if (i == 8) begin
                checks++; if (state !== 2'd0) begin errors++; $display("FAIL wu_idle got %0d exp 0", state); end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL wu_done got %b exp 1", done); end
            end
        end
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL wu_level got %0d exp 4", fifo_level); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wu_irq got %b exp 1", irq); end
        drain("wu");
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wu_irq_sticky got %b exp 1", irq); end
    endtask

    task automatic test_continuous();
        logic [15:0] v;
        irq_level = 4'd4;
        do_start(16'd0, 16'd0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ct_state got %0d exp 2", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ct_done_clr got %b exp 0", done); end
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            model_in(v, 1'b1);
            send(v);
            if (i == 2) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ct_irq_early got %b exp 0", irq); end
            end
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ct_irq got %b exp 1", irq); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ct_busy got %b exp 1", busy); end
        do_stop();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ct_stop_state got %0d exp 0", state); end
        checks++; if ({done, mic_clk_en} !== 2'b00) begin errors++; $display("FAIL ct_stop_flags got %b exp 00", {done, mic_clk_en}); end
        drain("ct");
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ct_irq_clear got %b exp 0", irq); end
        irq_level = 4'd0;
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        do_start(16'd0, 16'd10);
        for (int i = 0; i < 10; i++) begin
            v = 16'h0100 + 16'(i);
            model_in(v, i < 8);
            send(v);
            if (i == 7) begin
                checks++; if ({fifo_level, overflow} !== {4'd8, 1'b0}) begin errors++; $display("FAIL ov_full got lvl %0d ovf %b exp 8 0", fifo_level, overflow); end
            end
        end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ov_state got %0d exp 3", state); end
        cycle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ov_done got %b exp 1", done); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ov_level got %0d exp 8", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_flag got %b exp 1", overflow); end
        checks++; if (fifo_data !== exp_q[0]) begin errors++; $display("FAIL ov_head got %h exp %h", fifo_data, exp_q[0]); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        exp_q.delete();
        checks++; if ({fifo_level, overflow} !== {4'd0, 1'b0}) begin errors++; $display("FAIL ov_flush got lvl %0d ovf %b exp 0 0", fifo_level, overflow); end
        checks++; if (fifo_data !== 16'h0) begin errors++; $display("FAIL ov_flush_data got %h exp 0", fifo_data); end
    endtask

    task automatic test_full_pushpop();
        logic [15:0] v;
        logic [15:0] e;
        do_start(16'd0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            v = 16'h0A00 + 16'(i);
            model_in(v, 1'b1);
            send(v);
        end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL pp_fill got %0d exp 8", fifo_level); end
        e = exp_q.pop_front();
        checks++; if (fifo_data !== e) begin errors++; $display("FAIL pp_head0 got %h exp %h", fifo_data, e); end
        v = 16'hBEEF;
        model_in(v, 1'b1);
        pcm_valid = 1'b1; pcm_data = v; fifo_pop = 1'b1;
        cycle();
        pcm_valid = 1'b0; fifo_pop = 1'b0;
        checks++; if ({fifo_level, overflow} !== {4'd8, 1'b0}) begin errors++; $display("FAIL pp_level got lvl %0d ovf %b exp 8 0", fifo_level, overflow); end
        checks++; if (fifo_data !== exp_q[0]) begin errors++; $display("FAIL pp_head1 got %h exp %h", fifo_data, exp_q[0]); end
        do_stop();
        drain("pp");
        fifo_pop = 1'b1;
        cycle();
        fifo_pop = 1'b0;
        checks++; if ({fifo_level, fifo_data} !== 20'h0) begin errors++; $display("FAIL pp_pop_empty got lvl %0d data %h exp 0 0", fifo_level, fifo_data); end
    endtask

    task automatic test_start_stop();
        warmup_count = 16'd0; sample_count = 16'd0;
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        checks++; if ({state, mic_clk_en} !== 3'b000) begin errors++; $display("FAIL ss_both got st %0d mic %b exp 0 0", state, mic_clk_en); end
        do_start(16'd0, 16'd3);
        model_in(16'h0031, 1'b1);
        send(16'h0031);
        warmup_count = 16'd7; sample_count = 16'd9;
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if ({state, busy} !== {2'd2, 1'b1}) begin errors++; $display("FAIL ss_ignored got st %0d busy %b exp 2 1", state, busy); end
        model_in(16'h0032, 1'b1);
        send(16'h0032);
        model_in(16'h0033, 1'b1);
        send(16'h0033);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ss_count got %0d exp 3", state); end
        cycle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ss_done got %b exp 1", done); end
        drain("ss");
    endtask

`ifdef PDM_CAPTURE_DCBLOCK_EN
    task automatic test_dcblock();
        logic [15:0] e;
        logic [15:0] mag;
        do_start(16'd0, 16'd0);
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if (fifo_data !== e) begin errors++; $display("FAIL dc_data[%0d] got %h exp %h", i, fifo_data, e); end
                fifo_pop = 1'b1;
            end
            model_in(16'd1000, 1'b1);
            pcm_valid = 1'b1; pcm_data = 16'd1000;
            cycle();
            pcm_valid = 1'b0; fifo_pop = 1'b0;
            if (i == 0) begin
                checks++; if (fifo_data !== 16'd1000) begin errors++; $display("FAIL dc_first got %0d exp 1000", fifo_data); end
            end
        end
        mag = fifo_data[15] ? -fifo_data : fifo_data;
        checks++; if (mag >= 16'd10) begin errors++; $display("FAIL dc_decay got %0d exp below 10", mag); end
        do_stop();
        drain("dc");
    endtask
`endif

    initial begin
        test_reset();
        test_warmup_capture();
        test_continuous();
        test_overflow();
        test_full_pushpop();
        test_start_stop();
`ifdef PDM_CAPTURE_DCBLOCK_EN
        test_dcblock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
